instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch stage of the ZAFx32 core, between the program counter and decode. Issues one instruction-memory request at a time from the current PC and drives the PC load strobe and next address: PC+4 sequentially, or the execute-stage target on a redirect. Delivers fetched instructions to decode through a valid/ready pipeline register backed by a one-entry skid buffer.

## Interface
- ADDR_W, 32, instruction address width
- DATA_W, 32, instruction word width
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pc_addr  in  ADDR_W  current PC value (program counter output)
- pc_ctrl  out  ADDR_W-independent 1  registered PC load strobe; one-cycle pulse
- pc_next  out  ADDR_W  registered address the PC loads when pc_ctrl=1
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_W  request address, equals pc_addr
- imem_gnt  in  1  request accepted this cycle (meaningful only with imem_req)
- imem_rvalid  in  1  response valid; cannot be back-pressured; earliest 1 cycle after gnt
- imem_rdata  in  DATA_W  instruction word
- redirect_valid  in  1  branch/jump taken, one-cycle pulse
- redirect_addr  in  ADDR_W  redirect target
- id_valid  out  1  instruction available to decode
- id_instr  out  DATA_W  instruction word
- id_pc  out  ADDR_W  address of id_instr
- id_ready  in  1  decode accepts this cycle (transfer = id_valid & id_ready)

## Operation
- FSM states: IDLE, REQ, WAIT, DROP. Reset state IDLE.
- IDLE: one cycle, lets PC settle; -> REQ.
- REQ: imem_req=1 only while skid buffer empty. On imem_gnt: latch fetch_pc=pc_addr; register pc_ctrl=1, pc_next=fetch_pc+4 (modulo 2^ADDR_W); -> WAIT.
- WAIT: on imem_rvalid, write {imem_rdata, fetch_pc} into output register if empty or transferring this cycle, else into skid; -> REQ.
- DROP: outstanding response belongs to killed path; on imem_rvalid discard data; -> REQ.
- Redirect (highest priority, any state): register pc_ctrl=1, pc_next=redirect_addr; clear id_valid and skid; next state DROP if a grant is outstanding (WAIT, or gnt in this same cycle), else IDLE. If imem_rvalid coincides with redirect, response is discarded and next state is IDLE.
- Skid drains into output register on transfer; id_valid stays 1 while either entry holds data.
- Output stability: while id_valid=1 and id_ready=0, id_instr/id_pc hold.

## Timing
- Reset values: pc_ctrl 0, pc_next 0, imem_req 0, id_valid 0, id_instr 0 (NOP), id_pc 0, skid empty.
- pc_ctrl/pc_next registered at posedge N+1 after grant/redirect at edge N; PC loads on following falling edge; new pc_addr valid at edge N+2.
- Best-case sequential throughput: one instruction per 2 cycles with 1-cycle memory (gnt edge N, rvalid edge N+1, next REQ edge N+1).
- Redirect-to-first-request: 2 cycles (IDLE bubble) without outstanding fetch.
- At most one outstanding request; imem_req never asserted in WAIT/DROP/IDLE.
- Reset mid-operation: all state cleared immediately; imem shares reset, so no stale response.

## Structure
- Shared package fetch_pkg: fetch state enum, NOP_INSTR = 32'h0000_0000, PC_INCR = 4.
- Sub-module fetch_skid_buffer: output register + one skid entry with valid/ready, flush input; FSM and PC logic stay in instr_fetch_unit.

## Test plan
- Reset then imem gnt/rvalid every opportunity, id_ready=1 -> id_pc sequence 0,4,8,12; pc_next 4,8,12 with one pc_ctrl pulse each.
- id_ready=0 for 6 cycles -> output holds 0x0, skid fills with 0x4, imem_req stays 0; id_ready=1 -> 0x4 then 0x8 delivered in order, none lost.
- redirect_valid with target 0x100 during WAIT -> DROP, response discarded, pc_next=0x100, next id_pc=0x100.
- redirect coincident with imem_gnt -> that fetch's response dropped; redirect coincident with imem_rvalid -> discarded, IDLE then REQ at 0x100.
- pc_addr=0xFFFF_FFFC grant -> pc_next=0x0000_0000 (wrap).
- Assert reset while id_valid=1 and WAIT -> all outputs at reset values same cycle; after release fetch restarts at 0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the ZAFx32 fetch stage.
// State encoding, reset instruction and PC step.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          PC_INCR   = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Fetch-to-decode pipeline register with one skid entry.
// Keeps fetched words in order while decode stalls.
module fetch_skid_buffer
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              skid_full
);

  logic              out_v_q, out_v_d;
  logic [DATA_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic              xfer;

  assign xfer = out_v_q & out_ready;

  // Drain skid on transfer, then place new word in first free slot.
  always_comb begin
    out_v_d      = out_v_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_v_d     = skid_v_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (xfer) begin
      out_v_d     = skid_v_q;
      out_instr_d = skid_instr_q;
      out_pc_d    = skid_pc_q;
      skid_v_d    = 1'b0;
    end
    if (in_valid) begin
      if (!out_v_d) begin
        out_v_d     = 1'b1;
        out_instr_d = in_instr;
        out_pc_d    = in_pc;
      end else begin
        skid_v_d     = 1'b1;
        skid_instr_d = in_instr;
        skid_pc_d    = in_pc;
      end
    end
    if (flush) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end
  end

  // Output and skid registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_v_q      <= 1'b0;
      out_instr_q  <= DATA_W'(NOP_INSTR);
      out_pc_q     <= '0;
      skid_v_q     <= 1'b0;
      skid_instr_q <= DATA_W'(NOP_INSTR);
      skid_pc_q    <= '0;
    end else begin
      out_v_q      <= out_v_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_v_q     <= skid_v_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign out_valid = out_v_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign skid_full = skid_v_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// ZAFx32 instruction fetch stage.
// One outstanding imem request; PC update and redirect handling.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_ctrl,
  output logic [ADDR_W-1:0] pc_next,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  input  logic              id_ready
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              pc_ctrl_q, pc_ctrl_d;
  logic [ADDR_W-1:0] pc_next_q, pc_next_d;
  logic              wr_valid;
  logic              flush;
  logic              skid_full;
  logic              gnt;
  logic              busy;

  assign imem_req  = (state_q == REQ) & ~skid_full;
  assign imem_addr = pc_addr;
  assign gnt       = imem_req & imem_gnt;
  assign busy      = (state_q == WAIT) | (state_q == DROP);

  // Next state, PC strobe and response routing; redirect wins.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_ctrl_d  = 1'b0;
    pc_next_d  = pc_next_q;
    wr_valid   = 1'b0;
    flush      = 1'b0;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (gnt) begin
          fetch_pc_d = pc_addr;
          pc_ctrl_d  = 1'b1;
          pc_next_d  = pc_addr + ADDR_W'(PC_INCR);
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          wr_valid = 1'b1;
          state_d  = REQ;
        end
      end
      DROP: begin
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      pc_ctrl_d = 1'b1;
      pc_next_d = redirect_addr;
      flush     = 1'b1;
      wr_valid  = 1'b0;
      if (gnt || (busy && !imem_rvalid)) state_d = DROP;
      else state_d = IDLE;
    end
  end

  // FSM and PC-control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      pc_ctrl_q  <= 1'b0;
      pc_next_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_ctrl_q  <= pc_ctrl_d;
      pc_next_q  <= pc_next_d;
    end
  end

  assign pc_ctrl = pc_ctrl_q;
  assign pc_next = pc_next_q;

  fetch_skid_buffer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (wr_valid),
    .in_instr (imem_rdata),
    .in_pc    (fetch_pc_q),
    .out_ready(id_ready),
    .out_valid(id_valid),
    .out_instr(id_instr),
    .out_pc   (id_pc),
    .skid_full(skid_full)
  );

endmodule
